rc4_ksa_fsm: RTL
================

// Module: rc4_ksa_fsm
// PURPOSE
// - RC4 key-scheduling stage. It runs after S-RAM init (S[i]=i) and before the PRGA/decrypt FSM.
// - Runs 256 iterations of: j = j + S[i] + key[i mod 3]; swap S[i],S[j].
// - Works in place on the shared 256x8 S-RAM (RAM1).
// - Its done output is the start level for the downstream PRGA stage.
// PARAMETERS
// - RD_WAIT  2  idle cycles between presenting a RAM1 read address and sampling q_RAM1 (>=1)
// - WR_WAIT  2  idle cycles after each RAM1 write strobe before the next RAM1 access (>=0)
// PORTS
// - clk               in   1   system clock; every register updates on its rising edge
// - master_reset      in   1   synchronous, active-high reset; also the restart from FINISH
// - task_ksa_start    in   1   level from the init stage; must stay high for the whole run
// - secret_key        in   24  key; byte0=[23:16], byte1=[15:8], byte2=[7:0]
// - q_RAM1            in   8   RAM1 read data
// - address_out_RAM1  out  8   RAM1 address (registered)
// - data_to_RAM1      out  8   RAM1 write data (registered)
// - wren_to_RAM1      out  1   RAM1 write enable (registered, one-cycle strobe)
// - done              out  1   KSA complete; held high in FINISH
// BEHAVIOUR
// - Reset (master_reset=1), or task_ksa_start=0 in any state except FINISH:
//   - state=IDLE; i=0, j=0, kidx=0
//   - address_out_RAM1=0, data_to_RAM1=0, wren_to_RAM1=0, done=0
//   - Dropping start mid-run aborts; S-RAM contents are then undefined.
// - States and transitions:
//   - IDLE: start=1 -> RD_SI.
//   - RD_SI: addr<=i, wren<=0 -> WAIT_SI (RD_WAIT cycles).
//   - CALC_J: si<=q_RAM1; j<=j+q_RAM1+key[kidx], mod 256 (8-bit wrap, carries dropped) -> RD_SJ.
//   - RD_SJ: addr<=j -> WAIT_SJ (RD_WAIT cycles) -> SAVE_SJ.
//   - SAVE_SJ: sj<=q_RAM1 -> WR_J.
//   - WR_J: addr<=j, data<=si, wren<=1 -> WR_J_WAIT. WR_J_WAIT clears wren on its first cycle and lasts WR_WAIT cycles.
//   - WR_I: addr<=i, data<=sj, wren<=1 -> WR_I_WAIT (same rules as WR_J_WAIT) -> NEXT.
//   - NEXT: if i==255: done<=1 -> FINISH. Else i<=i+1; kidx<=(kidx==2)?0:kidx+1 -> RD_SI.
//   - FINISH: done=1, outputs frozen with wren=0; ignores start; leaves only on master_reset.
// - Index widths:
//   - i is 8-bit; termination is detected by compare at 255, never by overflow.
//   - kidx is a 2-bit wrap counter; no divider. kidx=3 is never reached.
// - Order of accesses:
//   - j is updated before S[j] is read, so the read uses the new j.
//   - Each read completes before the following write, so i==j needs no special handling.
// - Iteration length: 7+2*RD_WAIT+2*WR_WAIT cycles (15 at defaults).
//   - done goes high 256*15=3840 cycles after the edge that samples start=1 in IDLE.
// CONFIGURATION
// - KSA_SKIP_SELF_SWAP_EN defined:
//   - SAVE_SJ goes straight to NEXT when i==j; no write strobes for that iteration.
//   - Such an iteration takes 5+2*RD_WAIT cycles; final S contents are identical.
// - KSA_SKIP_SELF_SWAP_EN undefined: every iteration performs both writes, even when i==j.
// TESTING
// - Model S-RAM with identity init, key=0x010203:
//   - writes 1,2 are (addr1,data0),(addr0,data1)
//   - writes 3,4 are (addr3,data0),(addr1,data3)
// - Full run: final 256-byte S matches a C reference KSA for keys 0x000000, 0x000249, 0xFFFFFF.
// - Cycle count at defaults, macro off: done rises exactly 3840 cycles after start is sampled; wren stays 0 in FINISH.
// - Macro on, key=0x000000:
//   - i=0 (j=0) and i=1 (j=1) produce no wren pulse
//   - i=2 writes (addr3,data2) then (addr2,data3)
// - Drop start at cycle 1000 -> IDLE next edge, all outputs 0; re-raising start replays a full run from i=0.
// - In FINISH, toggle start -> done stays 1; master_reset=1 for one cycle -> done=0, state IDLE.

Source files
------------

// File: rtl/rc4_ksa_fsm.sv
// RC4 key-scheduling FSM: 256 read/read/write/write swap iterations on the shared S-RAM.
// Optional build macro KSA_SKIP_SELF_SWAP_EN drops both write strobes when i == j.
module rc4_ksa_fsm #(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic        clk,
    input  logic        master_reset,
    input  logic        task_ksa_start,
    input  logic [23:0] secret_key,
    input  logic [7:0]  q_RAM1,
    output logic [7:0]  address_out_RAM1,
    output logic [7:0]  data_to_RAM1,
    output logic        wren_to_RAM1,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WAIT_SI,
        CALC_J,
        RD_SJ,
        WAIT_SJ,
        SAVE_SJ,
        WR_J,
        WR_J_WAIT,
        WR_I,
        WR_I_WAIT,
        NEXT,
        FINISH
    } state_t;

    localparam logic [7:0] RD_LAST = 8'(RD_WAIT - 1);
    localparam logic [7:0] WR_LAST = 8'(WR_WAIT - 1);

    state_t     state, state_n;
    logic [7:0] i, i_n;
    logic [7:0] j, j_n;
    logic [1:0] kidx, kidx_n;
    logic [7:0] si, si_n;
    logic [7:0] sj, sj_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] addr_q, addr_n;
    logic [7:0] data_q, data_n;
    logic       wren_q, wren_n;
    logic       done_q, done_n;
    logic [7:0] key_byte;

    always_comb begin
        case (kidx)
            2'd0:    key_byte = secret_key[23:16];
            2'd1:    key_byte = secret_key[15:8];
            default: key_byte = secret_key[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (master_reset) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            kidx   <= '0;
            si     <= '0;
            sj     <= '0;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            wren_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            i      <= i_n;
            j      <= j_n;
            kidx   <= kidx_n;
            si     <= si_n;
            sj     <= sj_n;
            cnt    <= cnt_n;
            addr_q <= addr_n;
            data_q <= data_n;
            wren_q <= wren_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        i_n     = i;
        j_n     = j;
        kidx_n  = kidx;
        si_n    = si;
        sj_n    = sj;
        cnt_n   = cnt;
        addr_n  = addr_q;
        data_n  = data_q;
        wren_n  = 1'b0;
        done_n  = done_q;

        if (!task_ksa_start && state != FINISH) begin
            state_n = IDLE;
            i_n     = '0;
            j_n     = '0;
            kidx_n  = '0;
            addr_n  = '0;
            data_n  = '0;
            done_n  = 1'b0;
        end else begin
            case (state)
                IDLE: state_n = RD_SI;
                RD_SI: begin
                    addr_n  = i;
                    cnt_n   = '0;
                    state_n = WAIT_SI;
                end
                WAIT_SI: begin
                    if (cnt == RD_LAST) state_n = CALC_J;
                    else                cnt_n   = cnt + 8'd1;
                end
                CALC_J: begin
                    si_n    = q_RAM1;
                    j_n     = j + q_RAM1 + key_byte;
                    state_n = RD_SJ;
                end
                RD_SJ: begin
                    addr_n  = j;
                    cnt_n   = '0;
                    state_n = WAIT_SJ;
                end
                WAIT_SJ: begin
                    if (cnt == RD_LAST) state_n = SAVE_SJ;
                    else                cnt_n   = cnt + 8'd1;
                end
                SAVE_SJ: begin
                    sj_n    = q_RAM1;
`ifdef KSA_SKIP_SELF_SWAP_EN
                    state_n = (i == j) ? NEXT : WR_J;
`else
                    state_n = WR_J;
`endif
                end
                // wren defaults low, so each write state yields a single-cycle strobe
                WR_J: begin
                    addr_n  = j;
                    data_n  = si;
                    wren_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = (WR_WAIT == 0) ? WR_I : WR_J_WAIT;
                end
                WR_J_WAIT: begin
                    if (cnt == WR_LAST) state_n = WR_I;
                    else                cnt_n   = cnt + 8'd1;
                end
                WR_I: begin
                    addr_n  = i;
                    data_n  = sj;
                    wren_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = (WR_WAIT == 0) ? NEXT : WR_I_WAIT;
                end
                WR_I_WAIT: begin
                    if (cnt == WR_LAST) state_n = NEXT;
                    else                cnt_n   = cnt + 8'd1;
                end
                NEXT: begin
                    if (i == 8'hFF) begin
                        done_n  = 1'b1;
                        state_n = FINISH;
                    end else begin
                        i_n     = i + 8'd1;
                        kidx_n  = (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
                        state_n = RD_SI;
                    end
                end
                FINISH:  state_n = FINISH;
                default: state_n = IDLE;
            endcase
        end
    end

    assign address_out_RAM1 = addr_q;
    assign data_to_RAM1     = data_q;
    assign wren_to_RAM1     = wren_q;
    assign done             = done_q;

endmodule
